// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: walks a registered register/value table and issues one
// I2C write per entry to a byte-level master. A NACK is retried after a
// back-off, up to MAX_RETRIES times. A run starts on a start pulse or on a
// rising edge of the (optionally synchronised) hot-plug detect.
//
// Handshake: i2c_req is a level. It rises together with a freshly registered
// i2c_word and stays high, with i2c_word frozen, until the master returns a
// one-cycle i2c_done. i2c_nack is only meaningful in that i2c_done cycle.
// i2c_done is ignored in every state other than WAIT.
module i2c_cfg_sequencer #(
    parameter logic [7:0] DEV_ADDR       = 8'h72,
    parameter int         NUM_ENTRIES    = 20,
    parameter int         IDX_W          = 6,
    parameter int         MAX_RETRIES    = 3,
    parameter int         BACKOFF_CYCLES = 1024,
    parameter int         HPD_SYNC       = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic             hpd,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [15:0]      tbl_data,
    output logic             i2c_req,
    output logic [23:0]      i2c_word,
    input  logic             i2c_done,
    input  logic             i2c_nack,
    output logic             busy,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [IDX_W-1:0] err_idx,
    output logic [2:0]       fsm_state
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] FETCH   = 3'd1;
    localparam logic [2:0] LATCH   = 3'd2;
    localparam logic [2:0] WAIT    = 3'd3;
    localparam logic [2:0] BACKOFF = 3'd4;
    localparam logic [2:0] NEXT    = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;
    localparam logic [2:0] ERROR   = 3'd7;

    // Retry counter must hold MAX_RETRIES; keep at least one bit when it is 0.
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int BW = $clog2(BACKOFF_CYCLES + 1);

    localparam logic [RW-1:0]    MAX_R    = RW'(MAX_RETRIES);
    localparam logic [BW-1:0]    BO_LOAD  = BW'(BACKOFF_CYCLES);
    localparam logic [BW-1:0]    BO_LAST  = BW'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    logic [2:0]    state;
    logic [RW-1:0] retry_cnt;
    logic [BW-1:0] bo_cnt;
    logic          hpd_s;
    logic          hpd_prev;
    logic          trigger;

    generate
        if (HPD_SYNC != 0) begin : g_sync
            logic [1:0] sync_ff;
            // Two-flop synchroniser for the asynchronous hot-plug level.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) sync_ff <= 2'b00;
                else        sync_ff <= {sync_ff[0], hpd};
            end
            assign hpd_s = sync_ff[1];
        end else begin : g_nosync
            assign hpd_s = hpd;
        end
    endgenerate

    // HPD history for rising-edge detection.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) hpd_prev <= 1'b0;
        else        hpd_prev <= hpd_s;
    end

    assign trigger   = start | (hpd_s & ~hpd_prev);
    assign fsm_state = state;

    // Sequencer FSM with all registered outputs. The BACKOFF state occupies
    // exactly BACKOFF_CYCLES cycles; LATCH then re-registers the same word.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            tbl_idx   <= '0;
            i2c_word  <= '0;
            err_idx   <= '0;
            i2c_req   <= 1'b0;
            busy      <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            retry_cnt <= '0;
            bo_cnt    <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (trigger) begin
                        cfg_done  <= 1'b0;
                        cfg_err   <= 1'b0;
                        retry_cnt <= '0;
                        tbl_idx   <= '0;
                        busy      <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    state <= LATCH;
                end
                LATCH: begin
                    i2c_word <= {DEV_ADDR, tbl_data};
                    i2c_req  <= 1'b1;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (i2c_done) begin
                        i2c_req <= 1'b0;
                        if (!i2c_nack) begin
                            retry_cnt <= '0;
                            state     <= NEXT;
                        end else if (retry_cnt < MAX_R) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            bo_cnt    <= BO_LOAD;
                            state     <= BACKOFF;
                        end else begin
                            err_idx <= tbl_idx;
                            cfg_err <= 1'b1;
                            busy    <= 1'b0;
                            state   <= ERROR;
                        end
                    end
                end
                BACKOFF: begin
                    bo_cnt <= bo_cnt - 1'b1;
                    if (bo_cnt <= BO_LAST) state <= LATCH;
                end
                NEXT: begin
                    if (tbl_idx == LAST_IDX) begin
                        cfg_done <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end else begin
                        tbl_idx <= tbl_idx + 1'b1;
                        state   <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: a default-parameter instance driven by a
// table of run scenarios, plus a NUM_ENTRIES=1 / MAX_RETRIES=0 instance
// exercised by hand-written sequences.
module tb_i2c_cfg_sequencer;

    localparam int N0  = 20;
    localparam int MR0 = 3;
    localparam int BO0 = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance 0 (defaults)
    logic        start0 = 1'b0, hpd0 = 1'b0, done0 = 1'b0, nack0 = 1'b0;
    logic        req0, busy0, cfg_done0, cfg_err0;
    logic [5:0]  idx0, err_idx0;
    logic [15:0] data0;
    logic [23:0] word0;
    logic [2:0]  st0;

    // instance 1 (single entry, no retry)
    logic        start1 = 1'b0, hpd1 = 1'b0, done1 = 1'b0, nack1 = 1'b0;
    logic        req1, busy1, cfg_done1, cfg_err1;
    logic [5:0]  idx1, err_idx1;
    logic [15:0] data1;
    logic [23:0] word1;
    logic [2:0]  st1;

    i2c_cfg_sequencer dut0 (
        .CLK(clk), .RST_N(rst_n), .start(start0), .hpd(hpd0),
        .tbl_idx(idx0), .tbl_data(data0), .i2c_req(req0), .i2c_word(word0),
        .i2c_done(done0), .i2c_nack(nack0), .busy(busy0), .cfg_done(cfg_done0),
        .cfg_err(cfg_err0), .err_idx(err_idx0), .fsm_state(st0)
    );

    i2c_cfg_sequencer #(
        .DEV_ADDR(8'h5A), .NUM_ENTRIES(1), .IDX_W(6), .MAX_RETRIES(0),
        .BACKOFF_CYCLES(4), .HPD_SYNC(0)
    ) dut1 (
        .CLK(clk), .RST_N(rst_n), .start(start1), .hpd(hpd1),
        .tbl_idx(idx1), .tbl_data(data1), .i2c_req(req1), .i2c_word(word1),
        .i2c_done(done1), .i2c_nack(nack1), .busy(busy1), .cfg_done(cfg_done1),
        .cfg_err(cfg_err1), .err_idx(err_idx1), .fsm_state(st1)
    );

    int checks   = 0;
    int failures = 0;

    function automatic logic [15:0] rom_val(input int i);
        if (i == 0) return 16'h4110;
        return {8'(8'h20 + i), 8'(8'h9C ^ (i * 7))};
    endfunction

    // registered ROM models
    always @(posedge clk) begin
        data0 <= rom_val(int'(idx0));
        data1 <= rom_val(int'(idx1));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- I2C master model for instance 0 ----------------
    int          nack_left[N0];
    int          age0 = 0;
    int          gap0 = 0;
    bit          in_gap0 = 1'b0;
    bit          last_nack0 = 1'b0;
    logic [23:0] wlog[$];
    int          gap_log[$];
    bit          gap_nack[$];

    // done pulse 5 cycles after req; logs each word and each req-low gap
    initial begin
        forever begin
            @(posedge clk); #1;
            done0 = 1'b0;
            nack0 = 1'b0;
            if (!rst_n) begin
                age0    = 0;
                in_gap0 = 1'b0;
            end else if (req0) begin
                if (in_gap0) begin
                    gap_log.push_back(gap0);
                    gap_nack.push_back(last_nack0);
                    in_gap0 = 1'b0;
                end
                age0++;
                if (age0 == 5) begin
                    wlog.push_back(word0);
                    done0 = 1'b1;
                    if (int'(idx0) < N0 && nack_left[int'(idx0)] > 0) begin
                        nack0 = 1'b1;
                        nack_left[int'(idx0)]--;
                    end
                    last_nack0 = nack0;
                    age0       = 0;
                    in_gap0    = 1'b1;
                    gap0       = 0;
                end
            end else if (in_gap0) begin
                gap0++;
            end
        end
    end

    // ---------------- scenario table ----------------
    typedef struct {
        string name;
        int    nack_entry;   // -1: none
        int    nack_cnt;
        bit    use_hpd;      // trigger via hpd rising edge instead of start
        bit    noise;        // toggle hpd / pulse start while busy
        int    exp_writes;
        bit    exp_done;
        bit    exp_err;
        int    exp_err_idx;
        int    exp_last_idx;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        logic [23:0] exp_q[$];
        int  cyc;
        int  first_req;
        int  nack_gaps;
        int  exp_retries;
        bit  seen_busy;
        for (int e = 0; e < N0; e++) nack_left[e] = 0;
        if (v.nack_entry >= 0) nack_left[v.nack_entry] = v.nack_cnt;
        wlog.delete();
        gap_log.delete();
        gap_nack.delete();
        in_gap0 = 1'b0;
        // expected write sequence from the scenario itself
        for (int e = 0; e < N0; e++) begin
            int att;
            bit fail_e;
            att    = 1;
            fail_e = 1'b0;
            if (e == v.nack_entry) begin
                if (v.nack_cnt > MR0) begin
                    att    = MR0 + 1;
                    fail_e = 1'b1;
                end else begin
                    att = v.nack_cnt + 1;
                end
            end
            for (int a = 0; a < att; a++) exp_q.push_back({8'h72, rom_val(e)});
            if (fail_e) break;
        end
        exp_retries = (v.nack_entry < 0) ? 0 : ((v.nack_cnt > MR0) ? MR0 : v.nack_cnt);

        if (v.use_hpd) hpd0 = 1'b1;
        else           start0 = 1'b1;
        cyc       = 0;
        first_req = -1;
        seen_busy = 1'b0;
        while (cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            start0 = 1'b0;
            if (busy0 && !seen_busy) begin
                seen_busy = 1'b1;
                chk({v.name, "_clr_done"}, 32'(cfg_done0), 32'd0);
                chk({v.name, "_clr_err"}, 32'(cfg_err0), 32'd0);
                chk({v.name, "_idx0"}, 32'(idx0), 32'd0);
            end
            if (req0 && first_req < 0) first_req = cyc;
            if (v.noise && busy0 && cyc < 120) begin
                if (cyc % 13 == 0) hpd0 = ~hpd0;
                if (cyc % 17 == 0) start0 = 1'b1;
            end
            if (seen_busy && !busy0) break;
        end
        chk({v.name, "_timeout"}, 32'(seen_busy && !busy0), 32'd1);
        // start: FETCH, LATCH then req; hpd adds two synchroniser cycles
        chk({v.name, "_latency"}, 32'(first_req), v.use_hpd ? 32'd5 : 32'd3);
        repeat (3) @(posedge clk);
        #1;
        hpd0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk({v.name, "_writes"}, 32'(wlog.size()), 32'(v.exp_writes));
        chk({v.name, "_model_writes"}, 32'(wlog.size()), 32'(exp_q.size()));
        for (int i = 0; i < wlog.size() && i < exp_q.size(); i++)
            chk({v.name, "_word"}, 32'(wlog[i]), 32'(exp_q[i]));
        nack_gaps = 0;
        for (int i = 0; i < gap_log.size(); i++) begin
            // after NACK: back-off window plus the LATCH cycle; after ACK: NEXT, FETCH, LATCH
            chk({v.name, gap_nack[i] ? "_backoff_gap" : "_ack_gap"}, 32'(gap_log[i]),
                gap_nack[i] ? 32'(BO0 + 1) : 32'd3);
            if (gap_nack[i]) nack_gaps++;
        end
        chk({v.name, "_retries"}, 32'(nack_gaps), 32'(exp_retries));
        chk({v.name, "_cfg_done"}, 32'(cfg_done0), 32'(v.exp_done));
        chk({v.name, "_cfg_err"}, 32'(cfg_err0), 32'(v.exp_err));
        if (v.exp_err) chk({v.name, "_err_idx"}, 32'(err_idx0), 32'(v.exp_err_idx));
        chk({v.name, "_tbl_idx"}, 32'(idx0), 32'(v.exp_last_idx));
        chk({v.name, "_busy"}, 32'(busy0), 32'd0);
        chk({v.name, "_req_idle"}, 32'(req0), 32'd0);
    endtask

    // reset asserted while a write is outstanding
    task automatic reset_midrun();
        int n;
        start0 = 1'b1;
        n = 0;
        while (!req0 && n < 10) begin
            @(posedge clk); #1;
            start0 = 1'b0;
            n++;
        end
        chk("midrun_req_seen", 32'(req0), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrun_req", 32'(req0), 32'd0);
        chk("midrun_busy", 32'(busy0), 32'd0);
        chk("midrun_idx", 32'(idx0), 32'd0);
        chk("midrun_word", 32'(word0), 32'd0);
        chk("midrun_err_idx", 32'(err_idx0), 32'd0);
        chk("midrun_cfg_err", 32'(cfg_err0), 32'd0);
        chk("midrun_cfg_done", 32'(cfg_done0), 32'd0);
        chk("midrun_state", 32'(st0), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        in_gap0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // one run on the single-entry instance, master answered by hand
    task automatic dut1_run(input string name, input bit nack, input bit exp_done, input bit exp_err);
        int n;
        int extra;
        start1 = 1'b1;
        n = 0;
        while (!req1 && n < 10) begin
            @(posedge clk); #1;
            start1 = 1'b0;
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'd3);
        chk({name, "_word"}, 32'(word1), 32'h5A4110);
        @(posedge clk); #1;
        done1 = 1'b1;
        nack1 = nack;
        @(posedge clk); #1;
        done1 = 1'b0;
        nack1 = 1'b0;
        chk({name, "_req_drop"}, 32'(req1), 32'd0);
        extra = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (req1) extra++;
        end
        chk({name, "_no_more_req"}, 32'(extra), 32'd0);
        chk({name, "_cfg_done"}, 32'(cfg_done1), 32'(exp_done));
        chk({name, "_cfg_err"}, 32'(cfg_err1), 32'(exp_err));
        if (exp_err) chk({name, "_err_idx"}, 32'(err_idx1), 32'd0);
        chk({name, "_busy"}, 32'(busy1), 32'd0);
        chk({name, "_idx"}, 32'(idx1), 32'd0);
    endtask

    initial begin
        vecs[0] = '{"ack_all",   -1, 0, 1'b0, 1'b0, 20, 1'b1, 1'b0, 0, 19};
        vecs[1] = '{"nack3x2",    3, 2, 1'b0, 1'b0, 22, 1'b1, 1'b0, 0, 19};
        vecs[2] = '{"nack5x4",    5, 4, 1'b0, 1'b0,  9, 1'b0, 1'b1, 5,  5};
        vecs[3] = '{"nack19x3",  19, 3, 1'b0, 1'b0, 23, 1'b1, 1'b0, 0, 19};
        vecs[4] = '{"hpd_rerun", -1, 0, 1'b1, 1'b1, 20, 1'b1, 1'b0, 0, 19};
        vecs[5] = '{"nack0x4",    0, 4, 1'b0, 1'b0,  4, 1'b0, 1'b1, 0,  0};

        // reset values, held in reset and after release
        repeat (3) @(posedge clk);
        #1;
        chk("rst_idx", 32'(idx0), 32'd0);
        chk("rst_word", 32'(word0), 32'd0);
        chk("rst_req", 32'(req0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_cfg_done", 32'(cfg_done0), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err0), 32'd0);
        chk("rst_err_idx", 32'(err_idx0), 32'd0);
        chk("rst_state", 32'(st0), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_req", 32'(req0), 32'd0);
        chk("idle_busy", 32'(busy0), 32'd0);

        for (int i = 0; i < 6; i++) begin
            if (i == 3) reset_midrun();
            run_vec(vecs[i]);
        end

        dut1_run("single_ack", 1'b0, 1'b1, 1'b0);
        dut1_run("single_nack", 1'b1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
